// File: rtl/efb_arb_pkg.sv
// Shared definitions for the EFB Wishbone arbiter: FSM encoding,
// requester indices and default watchdog settings (WB_TIMEOUT_EN builds).
package efb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_HW  = 1'b1;

  localparam int         DEFAULT_TIMEOUT_CYCLES = 255;
  localparam logic [7:0] DEFAULT_TIMEOUT_DATA   = 8'hEE;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. A lone request always wins; on a tie the
// requester that was not granted last time wins.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant_valid,
  output logic grant_idx
);

  // Pick the winner purely from current requests and the last-granted pointer.
  always_comb begin
    grant_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant_idx = ~last;
    end else begin
      grant_idx = valid1;
    end
  end

endmodule

// File: rtl/efb_wb_arbiter.sv
// Arbiter/sequencer in front of the EFB 8-bit Wishbone slave port.
// Two requesters with picorv32-style valid/ready; one Wishbone classic
// cycle at a time. Optional bus watchdog enabled by defining WB_TIMEOUT_EN.
//
// Handshake: a requester raises rN_valid with we/addr/wdata stable and holds
// it until it sees rN_ready=1 for one cycle; it must drop valid on the edge
// where it samples ready. rN_rdata/rN_err are meaningful only while rN_ready=1.
// On the Wishbone side, cyc/stb stay high with address/data stable until the
// slave's ack is sampled on a rising clk edge.
module efb_wb_arbiter
  import efb_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
`ifdef WB_TIMEOUT_EN
  ,
  parameter int                TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = DATA_W'(DEFAULT_TIMEOUT_DATA)
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack,
  output logic              gnt,
  output arb_state_t        dbg_state
);

  arb_state_t state_q;
  logic       last_q;
  logic       gnt_q;
  logic       cyc_q;
  logic       we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic       r0_ready_q, r1_ready_q;
  logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;
  logic       grant_valid;
  logic       grant_idx;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] cnt_q;
  logic             r0_err_q, r1_err_q;
`endif

  rr_arb2 u_pick (
    .valid0      (r0_valid),
    .valid1      (r1_valid),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Sequencer FSM: IDLE grants and latches, BUS waits for ack, DONE pulses ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      last_q     <= REQ_HW;
      gnt_q      <= REQ_HW;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= '0;
      r0_err_q   <= 1'b0;
      r1_err_q   <= 1'b0;
`endif
    end else begin
      // Ready is a single-cycle pulse; it is only raised on the edge into DONE.
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            gnt_q   <= grant_idx;
            we_q    <= (grant_idx == REQ_HW) ? r1_we    : r0_we;
            adr_q   <= (grant_idx == REQ_HW) ? r1_addr  : r0_addr;
            dat_q   <= (grant_idx == REQ_HW) ? r1_wdata : r0_wdata;
            cyc_q   <= 1'b1;
            state_q <= BUS;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        BUS: begin
          if (wb_ack) begin
            // Ack wins even if the watchdog expires in the same cycle.
            cyc_q   <= 1'b0;
            state_q <= DONE;
            if (gnt_q == REQ_CPU) begin
              r0_ready_q <= 1'b1;
              r0_rdata_q <= wb_dat_i;
`ifdef WB_TIMEOUT_EN
              r0_err_q   <= 1'b0;
`endif
            end else begin
              r1_ready_q <= 1'b1;
              r1_rdata_q <= wb_dat_i;
`ifdef WB_TIMEOUT_EN
              r1_err_q   <= 1'b0;
`endif
            end
          end
`ifdef WB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Counter counts completed BUS cycles; this is the last allowed one.
            cyc_q   <= 1'b0;
            state_q <= DONE;
            if (gnt_q == REQ_CPU) begin
              r0_ready_q <= 1'b1;
              r0_rdata_q <= TIMEOUT_DATA;
              r0_err_q   <= 1'b1;
            end else begin
              r1_ready_q <= 1'b1;
              r1_rdata_q <= TIMEOUT_DATA;
              r1_err_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          last_q  <= gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_cyc    = cyc_q;
  assign wb_stb    = cyc_q;
  assign wb_we     = we_q;
  assign wb_adr    = adr_q;
  assign wb_dat_o  = dat_q;
  assign gnt       = gnt_q;
  assign dbg_state = state_q;
  assign r0_ready  = r0_ready_q;
  assign r1_ready  = r1_ready_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
`ifdef WB_TIMEOUT_EN
  assign r0_err    = r0_err_q;
  assign r1_err    = r1_err_q;
`else
  assign r0_err    = 1'b0;
  assign r1_err    = 1'b0;
`endif

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Directed bench for efb_wb_arbiter. Timeout scenarios run when the bench
// is built with WB_TIMEOUT_EN defined (TIMEOUT_CYCLES=255, TIMEOUT_DATA=0xEE).
module tb_efb_wb_arbiter;
  import efb_arb_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       r0_valid, r0_we, r1_valid, r1_we;
  logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic       r0_ready, r1_ready, r0_err, r1_err;
  logic [7:0] r0_rdata, r1_rdata;
  logic       wb_cyc, wb_stb, wb_we, wb_ack, gnt;
  logic [7:0] wb_adr, wb_dat_o, wb_dat_i;
  arb_state_t dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  efb_wb_arbiter dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
    .gnt(gnt), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Advance one cycle; inputs driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_r0(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask

  task automatic drive_r1(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    checks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin failures++; $display("FAIL reset_cyc_stb_we got=%b want=000", {wb_cyc, wb_stb, wb_we}); end
    checks++; if ({wb_adr, wb_dat_o} !== 16'h0000) begin failures++; $display("FAIL reset_adr_dat got=%h want=0000", {wb_adr, wb_dat_o}); end
    checks++; if ({r0_ready, r1_ready, r0_err, r1_err} !== 4'b0000) begin failures++; $display("FAIL reset_ready_err got=%b want=0000", {r0_ready, r1_ready, r0_err, r1_err}); end
    checks++; if ({r0_rdata, r1_rdata} !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h want=0000", {r0_rdata, r1_rdata}); end
    checks++; if (gnt !== 1'b1) begin failures++; $display("FAIL reset_gnt got=%b want=1", gnt); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    drive_r0(1'b1, 1'b0, 8'h4A, 8'h00);
    tick();
    checks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b110) begin failures++; $display("FAIL read_bus_ctrl got=%b want=110", {wb_cyc, wb_stb, wb_we}); end
    checks++; if (wb_adr !== 8'h4A) begin failures++; $display("FAIL read_adr got=%h want=4a", wb_adr); end
    checks++; if (gnt !== 1'b0) begin failures++; $display("FAIL read_gnt got=%b want=0", gnt); end
    checks++; if (r0_ready !== 1'b0) begin failures++; $display("FAIL read_early_ready got=%b want=0", r0_ready); end
    wb_ack = 1'b1; wb_dat_i = 8'h5C;
    tick();
    wb_ack = 1'b0; wb_dat_i = 8'h00;
    checks++; if (r0_ready !== 1'b1) begin failures++; $display("FAIL read_ready got=%b want=1", r0_ready); end
    checks++; if (r0_rdata !== 8'h5C) begin failures++; $display("FAIL read_rdata got=%h want=5c", r0_rdata); end
    checks++; if (r0_err !== 1'b0) begin failures++; $display("FAIL read_err got=%b want=0", r0_err); end
    checks++; if (wb_cyc !== 1'b0) begin failures++; $display("FAIL read_cyc_drop got=%b want=0", wb_cyc); end
    drive_r0(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checks++; if (r0_ready !== 1'b0 || dbg_state !== IDLE) begin failures++; $display("FAIL read_ready_pulse got=%b/%0d want=0/%0d", r0_ready, dbg_state, IDLE); end
  endtask

  task automatic test_write_wait();
    drive_r1(1'b1, 1'b1, 8'h70, 8'h81);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin wb_ack = 1'b1; wb_dat_i = 8'h33; end
      checks++; if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o} !== {3'b111, 8'h70, 8'h81}) begin
        failures++; $display("FAIL write_hold[%0d] got=%b/%h/%h want=111/70/81", i, {wb_cyc, wb_stb, wb_we}, wb_adr, wb_dat_o);
      end
      checks++; if ({r0_ready, r1_ready} !== 2'b00) begin failures++; $display("FAIL write_wait_ready[%0d] got=%b want=00", i, {r0_ready, r1_ready}); end
    end
    tick();
    wb_ack = 1'b0; wb_dat_i = 8'h00;
    checks++; if ({r0_ready, r1_ready} !== 2'b01) begin failures++; $display("FAIL write_ready got=%b want=01", {r0_ready, r1_ready}); end
    checks++; if (r1_rdata !== 8'h33 || r0_rdata !== 8'h5C) begin failures++; $display("FAIL write_rdata got=%h/%h want=5c/33", r0_rdata, r1_rdata); end
    drive_r1(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checks++; if (r1_ready !== 1'b0) begin failures++; $display("FAIL write_ready_pulse got=%b want=0", r1_ready); end
  endtask

  task automatic test_contention();
    logic [7:0] exp_gnt;
    // Last grant was r1, so r0 wins the first tie.
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    drive_r0(1'b1, 1'b0, 8'h10, 8'h00);
    drive_r1(1'b1, 1'b0, 8'h20, 8'h00);
    for (int k = 0; k < 4; k++) begin
      exp_gnt = exp_q.pop_front();
      tick();
      checks++; if (gnt !== exp_gnt[0] || wb_adr !== (exp_gnt[0] ? 8'h20 : 8'h10)) begin
        failures++; $display("FAIL contend_gnt[%0d] got=%b/%h want=%b", k, gnt, wb_adr, exp_gnt[0]);
      end
      wb_ack = 1'b1; wb_dat_i = 8'hA0 + 8'(k);
      tick();
      wb_ack = 1'b0;
      checks++; if ({r1_ready, r0_ready} !== (exp_gnt[0] ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL contend_ready[%0d] got=%b want=%b", k, {r1_ready, r0_ready}, (exp_gnt[0] ? 2'b10 : 2'b01));
      end
      checks++; if ((exp_gnt[0] ? r1_rdata : r0_rdata) !== 8'hA0 + 8'(k)) begin
        failures++; $display("FAIL contend_rdata[%0d] got=%h want=%h", k, (exp_gnt[0] ? r1_rdata : r0_rdata), 8'hA0 + 8'(k));
      end
      tick();
      checks++; if ({r1_ready, r0_ready} !== 2'b00) begin failures++; $display("FAIL contend_pulse[%0d] got=%b want=00", k, {r1_ready, r0_ready}); end
    end
    drive_r0(1'b0, 1'b0, 8'h00, 8'h00);
    drive_r1(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_reset_mid();
    drive_r0(1'b1, 1'b0, 8'h33, 8'h00);
    tick();
    checks++; if (wb_cyc !== 1'b1) begin failures++; $display("FAIL rstmid_bus got=%b want=1", wb_cyc); end
    resetn = 1'b0;
    drive_r0(1'b0, 1'b0, 8'h00, 8'h00);
    drive_r1(1'b1, 1'b0, 8'h55, 8'h00);
    tick();
    checks++; if ({wb_cyc, wb_stb, r0_ready, r1_ready} !== 4'b0000) begin failures++; $display("FAIL rstmid_drop got=%b want=0000", {wb_cyc, wb_stb, r0_ready, r1_ready}); end
    checks++; if (dbg_state !== IDLE || gnt !== 1'b1) begin failures++; $display("FAIL rstmid_state got=%0d/%b want=%0d/1", dbg_state, gnt, IDLE); end
    resetn = 1'b1;
    tick();
    checks++; if (gnt !== 1'b1 || wb_adr !== 8'h55 || wb_cyc !== 1'b1) begin failures++; $display("FAIL rstmid_r1_alone got=%b/%h/%b want=1/55/1", gnt, wb_adr, wb_cyc); end
    wb_ack = 1'b1; wb_dat_i = 8'h66;
    tick();
    wb_ack = 1'b0;
    checks++; if ({r1_ready, r0_ready} !== 2'b10 || r1_rdata !== 8'h66) begin failures++; $display("FAIL rstmid_r1_done got=%b/%h want=10/66", {r1_ready, r0_ready}, r1_rdata); end
    drive_r1(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    // After a fresh reset, a tie goes to r0 even though r1 is pending.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    drive_r0(1'b1, 1'b0, 8'h11, 8'h00);
    drive_r1(1'b1, 1'b0, 8'h22, 8'h00);
    tick();
    checks++; if (gnt !== 1'b0 || wb_adr !== 8'h11) begin failures++; $display("FAIL rstmid_tie got=%b/%h want=0/11", gnt, wb_adr); end
    wb_ack = 1'b1; wb_dat_i = 8'h01;
    tick();
    wb_ack = 1'b0;
    drive_r0(1'b0, 1'b0, 8'h00, 8'h00);
    drive_r1(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_spurious_ack();
    wb_ack = 1'b1; wb_dat_i = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({wb_cyc, r0_ready, r1_ready} !== 3'b000 || dbg_state !== IDLE) begin
        failures++; $display("FAIL spurious_ack[%0d] got=%b/%0d want=000/%0d", i, {wb_cyc, r0_ready, r1_ready}, dbg_state, IDLE);
      end
    end
    checks++; if (r0_rdata !== 8'h01) begin failures++; $display("FAIL spurious_rdata got=%h want=01", r0_rdata); end
    wb_ack = 1'b0; wb_dat_i = 8'h00;
    tick();
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    drive_r0(1'b1, 1'b0, 8'h40, 8'h00);
    tick();
    n = 0;
    while (wb_cyc && n < 400) begin
      n++;
      tick();
    end
    drive_r0(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (n !== 255) begin failures++; $display("FAIL timeout_len got=%0d want=255", n); end
    checks++; if (r0_ready !== 1'b1 || r0_rdata !== 8'hEE || r0_err !== 1'b1) begin
      failures++; $display("FAIL timeout_result got=%b/%h/%b want=1/ee/1", r0_ready, r0_rdata, r0_err);
    end
    tick();
    drive_r0(1'b1, 1'b0, 8'h41, 8'h00);
    tick();
    for (int i = 0; i < 254; i++) tick();
    checks++; if (wb_cyc !== 1'b1) begin failures++; $display("FAIL timeout_edge_bus got=%b want=1", wb_cyc); end
    wb_ack = 1'b1; wb_dat_i = 8'h77;
    tick();
    wb_ack = 1'b0;
    drive_r0(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (r0_ready !== 1'b1 || r0_rdata !== 8'h77 || r0_err !== 1'b0) begin
      failures++; $display("FAIL timeout_ack_wins got=%b/%h/%b want=1/77/0", r0_ready, r0_rdata, r0_err);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    drive_r0(1'b1, 1'b0, 8'h40, 8'h00);
    for (int i = 0; i < 300; i++) tick();
    checks++; if (wb_cyc !== 1'b1 || r0_ready !== 1'b0) begin failures++; $display("FAIL no_timeout_wait got=%b/%b want=1/0", wb_cyc, r0_ready); end
    wb_ack = 1'b1; wb_dat_i = 8'h9A;
    tick();
    wb_ack = 1'b0;
    drive_r0(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (r0_ready !== 1'b1 || r0_rdata !== 8'h9A || r0_err !== 1'b0) begin
      failures++; $display("FAIL no_timeout_done got=%b/%h/%b want=1/9a/0", r0_ready, r0_rdata, r0_err);
    end
    tick();
  endtask
`endif

  initial begin
    resetn = 1'b0;
    wb_ack = 1'b0; wb_dat_i = 8'h00;
    drive_r0(1'b0, 1'b0, 8'h00, 8'h00);
    drive_r1(1'b0, 1'b0, 8'h00, 8'h00);
    test_reset();
    test_single_read();
    test_write_wait();
    test_contention();
    test_reset_mid();
    test_spurious_ack();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
